// File: rtl/rx_async_core.sv
// UART receive engine: 16x oversampled start/data/parity/stop framing with
// either a hold register (rxrdy/overflow) or a one-clk write strobe to an external FIFO.
module rx_async_core #(
    parameter bit RX_FIFO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       clear_status,
    input  logic       fifo_full,
    output logic [7:0] rx_dout,
    output logic       rxrdy,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       fifo_write_rx
);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    rx_state_t  state;
    logic       rx_m, rx_s;
    logic [3:0] samp_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       data_xor;
    logic       par_err_next;
    logic       mid_bit;
    logic       last_bit;
    logic       frame_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign mid_bit    = baud_clock && (samp_cnt == 4'hF);
    assign last_bit   = (bit_cnt == (bit8 ? 3'd7 : 3'd6));
    assign frame_done = (state == RX_STOP) && mid_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RX_IDLE;
            samp_cnt     <= 4'd0;
            bit_cnt      <= 3'd0;
            shift        <= 8'h00;
            data_xor     <= 1'b0;
            par_err_next <= 1'b0;
        end else begin
            case (state)
                RX_IDLE: begin
                    samp_cnt <= 4'd0;
                    bit_cnt  <= 3'd0;
                    if (!rx_s)
                        state <= RX_START;
                end
                RX_START: begin
                    // Re-check the line half a bit in; a high here was a glitch.
                    if (baud_clock) begin
                        if (samp_cnt == 4'd7) begin
                            samp_cnt <= 4'd0;
                            if (rx_s) begin
                                state <= RX_IDLE;
                            end else begin
                                state        <= RX_DATA;
                                bit_cnt      <= 3'd0;
                                data_xor     <= 1'b0;
                                par_err_next <= 1'b0;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (baud_clock)
                        samp_cnt <= samp_cnt + 4'd1;
                    if (mid_bit) begin
                        // LSB first: each new bit enters at the top of the character.
                        if (bit8)
                            shift <= {rx_s, shift[7:1]};
                        else
                            shift <= {1'b0, rx_s, shift[6:1]};
                        data_xor <= data_xor ^ rx_s;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (last_bit)
                            state <= parity_en ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (baud_clock)
                        samp_cnt <= samp_cnt + 4'd1;
                    if (mid_bit) begin
                        par_err_next <= rx_s ^ odd_n_even ^ data_xor;
                        state        <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (baud_clock)
                        samp_cnt <= samp_cnt + 4'd1;
                    if (mid_bit)
                        state <= rx_s ? RX_IDLE : RX_BREAK;
                end
                RX_BREAK: begin
                    samp_cnt <= 4'd0;
                    if (rx_s)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_dout       <= 8'h00;
            rxrdy         <= 1'b0;
            parity_err    <= 1'b0;
            framing_err   <= 1'b0;
            overflow      <= 1'b0;
            fifo_write_rx <= 1'b1;
        end else begin
            fifo_write_rx <= 1'b1;
            if (clear_status)
                overflow <= 1'b0;
            if (!RX_FIFO && read_rx_byte)
                rxrdy <= 1'b0;
            // Later assignments win, so a completion overrides the read/clear above.
            if (frame_done) begin
                if (RX_FIFO) begin
                    framing_err <= ~rx_s;
                    parity_err  <= parity_en & par_err_next;
                    if (!fifo_full) begin
                        rx_dout       <= shift;
                        fifo_write_rx <= 1'b0;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (!rxrdy || read_rx_byte) begin
                    framing_err <= ~rx_s;
                    parity_err  <= parity_en & par_err_next;
                    rx_dout     <= shift;
                    rxrdy       <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_async_core.sv
// Directed bench for rx_async_core: hold-register and FIFO-strobe instances share one serial line.
module tb_rx_async_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_clock;
    logic       rx = 1'b1;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       read_rx_byte = 1'b0;
    logic       clear_status = 1'b0;
    logic       fifo_full = 1'b0;

    logic [7:0] h_rx_dout, f_rx_dout;
    logic       h_rxrdy, h_parity_err, h_framing_err, h_overflow, h_fifo_write_rx;
    logic       f_rxrdy, f_parity_err, f_framing_err, f_overflow, f_fifo_write_rx;

    logic [1:0] bcnt = 2'd0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    int         wr_dbl = 0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_prev = 1'b1;
    int         w0;

    rx_async_core #(.RX_FIFO(1'b0)) u_hold (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_status(clear_status), .fifo_full(fifo_full),
        .rx_dout(h_rx_dout), .rxrdy(h_rxrdy), .parity_err(h_parity_err),
        .framing_err(h_framing_err), .overflow(h_overflow), .fifo_write_rx(h_fifo_write_rx)
    );

    rx_async_core #(.RX_FIFO(1'b1)) u_fifo (
        .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_status(clear_status), .fifo_full(fifo_full),
        .rx_dout(f_rx_dout), .rxrdy(f_rxrdy), .parity_err(f_parity_err),
        .framing_err(f_framing_err), .overflow(f_overflow), .fifo_write_rx(f_fifo_write_rx)
    );

    always #5 clk = ~clk;

    // One baud enable every 4 clks: a bit time is 64 clks.
    always @(posedge clk) bcnt <= bcnt + 2'd1;
    assign baud_clock = (bcnt == 2'd3);

    always @(negedge clk) begin
        wr_prev <= f_fifo_write_rx;
        if (!f_fifo_write_rx) begin
            wr_cnt  <= wr_cnt + 1;
            wr_data <= f_rx_dout;
            if (!wr_prev)
                wr_dbl <= wr_dbl + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves us 1 time unit after an edge where the next baud tick lands 4 edges later.
    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (bcnt != 2'd0);
    endtask

    // rd_edge: edge index (from frame start) at which read_rx_byte is high; -1 for none.
    task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit pb,
                              input bit sb, input int rd_edge);
        logic [10:0] bits;
        int          tot;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = d[i];
        tot = 1 + nb;
        if (pe) begin
            bits[tot] = pb;
            tot++;
        end
        bits[tot] = sb;
        tot++;
        align();
        for (int c = 0; c < 64 * tot; c++) begin
            rx           = bits[c/64];
            read_rx_byte = (c + 1 == rd_edge);
            @(posedge clk);
            #1;
        end
        read_rx_byte = 1'b0;
        clks(2);
    endtask

    task automatic pulse_read();
        read_rx_byte = 1'b1;
        clks(1);
        read_rx_byte = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        clks(1);
        clear_status = 1'b0;
    endtask

    initial begin
        clks(3);
        chk("rst h_dout", h_rx_dout, 8'h00);
        chk("rst h_rxrdy", h_rxrdy, 1'b0);
        chk("rst h_perr", h_parity_err, 1'b0);
        chk("rst h_ferr", h_framing_err, 1'b0);
        chk("rst h_ovf", h_overflow, 1'b0);
        chk("rst f_wr", f_fifo_write_rx, 1'b1);
        reset = 1'b0;
        clks(5);

        // 8N1
        send_frame(8'hA5, 8, 0, 0, 1, -1);
        chk("8n1 dout", h_rx_dout, 8'hA5);
        chk("8n1 rxrdy", h_rxrdy, 1'b1);
        chk("8n1 perr", h_parity_err, 1'b0);
        chk("8n1 ferr", h_framing_err, 1'b0);
        chk("8n1 fifo wr", wr_cnt, 1);
        chk("8n1 fifo data", wr_data, 8'hA5);
        chk("fifo rxrdy tied", f_rxrdy, 1'b0);
        pulse_read();
        chk("8n1 read", h_rxrdy, 1'b0);

        // 8O1: 0x3C has four ones, odd sense expects parity bit 1
        parity_en  = 1'b1;
        odd_n_even = 1'b1;
        send_frame(8'h3C, 8, 1, 0, 1, -1);
        chk("par bad perr", h_parity_err, 1'b1);
        chk("par bad dout", h_rx_dout, 8'h3C);
        pulse_read();
        send_frame(8'h3C, 8, 1, 1, 1, -1);
        chk("par ok perr", h_parity_err, 1'b0);
        pulse_read();

        // 7E1, then a frame with a low stop bit followed by a held-low line
        bit8       = 1'b0;
        odd_n_even = 1'b0;
        send_frame(8'h55, 7, 1, 0, 1, -1);
        chk("7e1 dout", h_rx_dout, 8'h55);
        chk("7e1 ferr", h_framing_err, 1'b0);
        chk("7e1 perr", h_parity_err, 1'b0);
        pulse_read();
        send_frame(8'h81, 7, 1, 1, 0, -1);
        chk("frm dout", h_rx_dout, 8'h01);
        chk("frm ferr", h_framing_err, 1'b1);
        chk("frm perr", h_parity_err, 1'b0);
        pulse_read();
        clks(1500);
        chk("brk rxrdy", h_rxrdy, 1'b0);
        chk("brk dout", h_rx_dout, 8'h01);
        chk("brk ovf", h_overflow, 1'b0);
        rx = 1'b1;
        clks(100);
        send_frame(8'h55, 7, 1, 0, 1, -1);
        chk("post brk dout", h_rx_dout, 8'h55);
        chk("post brk ferr", h_framing_err, 1'b0);
        pulse_read();

        // Glitch: low for 4 baud ticks only
        bit8      = 1'b1;
        parity_en = 1'b0;
        w0        = wr_cnt;
        align();
        rx = 1'b0;
        clks(16);
        rx = 1'b1;
        clks(300);
        chk("glitch rxrdy", h_rxrdy, 1'b0);
        chk("glitch dout", h_rx_dout, 8'h55);
        chk("glitch ferr", h_framing_err, 1'b0);
        chk("glitch fifo", wr_cnt - w0, 0);
        send_frame(8'hA5, 8, 0, 0, 1, -1);
        chk("after glitch", h_rx_dout, 8'hA5);
        pulse_read();

        // Overflow in hold mode
        send_frame(8'h11, 8, 0, 0, 1, -1);
        send_frame(8'h22, 8, 0, 0, 1, -1);
        chk("ovf dout", h_rx_dout, 8'h11);
        chk("ovf flag", h_overflow, 1'b1);
        chk("ovf rxrdy", h_rxrdy, 1'b1);
        pulse_clear();
        chk("ovf clear", h_overflow, 1'b0);
        // stop sample of an 8N1 frame lands on edge 32 + 64*9
        send_frame(8'h22, 8, 0, 0, 1, 608);
        chk("rd+done dout", h_rx_dout, 8'h22);
        chk("rd+done rxrdy", h_rxrdy, 1'b1);
        chk("rd+done ovf", h_overflow, 1'b0);
        pulse_read();

        // FIFO mode
        w0 = wr_cnt;
        send_frame(8'h7E, 8, 0, 0, 1, -1);
        chk("fifo strobes", wr_cnt - w0, 1);
        chk("fifo data", wr_data, 8'h7E);
        chk("fifo ovf", f_overflow, 1'b0);
        fifo_full = 1'b1;
        w0        = wr_cnt;
        send_frame(8'h7E, 8, 0, 0, 1, -1);
        chk("full strobes", wr_cnt - w0, 0);
        chk("full ovf", f_overflow, 1'b1);
        fifo_full = 1'b0;

        // Reset in the middle of the data bits; remaining bits are all ones
        w0 = wr_cnt;
        fork
            send_frame(8'hFC, 8, 0, 0, 1, -1);
            begin
                clks(266);
                reset = 1'b1;
                clks(3);
                reset = 1'b0;
            end
        join
        clks(20);
        chk("rst mid strobes", wr_cnt - w0, 0);
        chk("rst mid f_dout", f_rx_dout, 8'h00);
        chk("rst mid f_ovf", f_overflow, 1'b0);
        chk("rst mid f_wr", f_fifo_write_rx, 1'b1);
        chk("rst mid f_ferr", f_framing_err, 1'b0);
        chk("rst mid h_rxrdy", h_rxrdy, 1'b0);
        chk("rst mid h_dout", h_rx_dout, 8'h00);
        w0 = wr_cnt;
        send_frame(8'hC3, 8, 0, 0, 1, -1);
        chk("post rst strobes", wr_cnt - w0, 1);
        chk("post rst data", wr_data, 8'hC3);
        chk("no double strobe", wr_dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_async_core.md
# rx_async_core

Asynchronous UART receive engine for the CoreUARTapb datapath; counterpart of the transmit state machine on the same serial link. It oversamples the serial input at 16x using a one-clock baud enable, validates the start bit, and assembles 7- or 8-bit characters LSB-first with optional parity. It checks stop and parity, then presents the byte either through a hold register with ready/overflow flags or as a write strobe into the external RX FIFO.

## Interface
- RX_FIFO, 0, 0 = hold register only; 1 = push each byte to the external RX FIFO.
- clk  in  1  system clock; all logic runs on it.
- reset  in  1  asynchronous, active-high reset.
- baud_clock  in  1  one-clk-wide enable, 16 pulses per bit time.
- rx  in  1  serial input; asynchronous, idles high.
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits.
- parity_en  in  1  1 = a parity bit follows the data.
- odd_n_even  in  1  parity sense; expected bit = odd_n_even XOR (XOR of data bits).
- read_rx_byte  in  1  one-clk pulse; host consumed rx_dout.
- clear_status  in  1  one-clk pulse; clears overflow.
- fifo_full  in  1  external RX FIFO full; ignored when RX_FIFO=0.
- rx_dout  out  8  received byte; bit 7 forced to 0 in 7-bit mode.
- rxrdy  out  1  byte valid in rx_dout; tied 0 when RX_FIFO=1.
- parity_err  out  1  parity status of the last completed frame.
- framing_err  out  1  stop-bit status of the last completed frame.
- overflow  out  1  sticky flag: a byte was lost.
- fifo_write_rx  out  1  active-low one-clk write strobe; data on rx_dout.

## Operation
- **Input synchronizer:** rx passes through a 2-FF synchronizer; both flops reset to 1. All decisions use the synchronized value rx_s.
- **Counters:** a 4-bit sample counter increments on baud_clock only and wraps 15->0. A 3-bit bit counter tracks data bits.
- **State machine**, one-hot or encoded; reset state is rx_idle:
  - rx_idle: sample counter held at 0. rx_s==0 -> rx_start.
  - rx_start: on the baud_clock that brings the count to 7 (8th tick, mid start bit):
    - rx_s==0 -> rx_data, counter cleared.
    - rx_s==1 -> glitch; return to rx_idle with no status change.
  - rx_data: on each count-15 tick (mid-bit), shift rx_s into bit (N-1) of the shift register, LSB first, and update the running parity. After bit 8 (bit8=1) or bit 7 (bit8=0) -> rx_parity if parity_en, else rx_stop.
  - rx_parity: at mid-bit, compute parity_err_next = rx_s XOR odd_n_even XOR data_xor -> rx_stop.
  - rx_stop: at mid-bit, frame completes (see Completion) -> rx_idle if rx_s==1, else rx_break.
  - rx_break: wait for rx_s==1 -> rx_idle. This prevents a held-low line from retriggering.
- **Completion**, one clk, same edge as the stop sample:
  - framing_err <= ~rx_s.
  - parity_err <= parity_err_next, or 0 when parity_en=0.
  - RX_FIFO=0, rxrdy==0 or read_rx_byte==1 this cycle: load rx_dout, rxrdy <= 1.
  - RX_FIFO=0, otherwise: rx_dout and flags are kept, byte dropped, overflow <= 1.
  - RX_FIFO=1, fifo_full==0: load rx_dout, fifo_write_rx low for exactly the next clk.
  - RX_FIFO=1, fifo_full==1: no write, overflow <= 1.
- **Read and clear:**
  - read_rx_byte with no completion in that cycle -> rxrdy <= 0.
  - clear_status -> overflow <= 0. If a new overflow occurs in the same cycle, set wins.
- Config inputs must be stable while not in rx_idle; changes mid-frame are undefined.

## Timing
- **Reset values:**
  - rx_dout = 0x00.
  - rxrdy, parity_err, framing_err, overflow = 0.
  - fifo_write_rx = 1.
  - State = rx_idle; counters 0.
- Reset asserted mid-frame aborts the frame with no strobe or flag. After release the block waits in rx_idle for a falling rx_s.
- Start detect latency: 2 clk synchronizer plus 1 clk state registration.
- Data valid latency: rx_dout/rxrdy (or the fifo_write_rx low) appear 1 clk after the baud_clock edge that samples mid-stop.
- Frame length: 16*(1+N+P+1) baud ticks. The next start is accepted on the first low rx_s after returning to rx_idle, so back-to-back frames with one stop bit are received.
- fifo_write_rx is never low on two consecutive clks.

## Test plan
- **8N1:** 8N1, RX_FIFO=0, send 0xA5 -> rx_dout=0xA5, rxrdy=1, parity_err=0, framing_err=0. Then read_rx_byte -> rxrdy=0 next clk.
- **Parity error:** 8 bits, parity_en=1, odd_n_even=1, send 0x3C with parity bit 0 (expected 1) -> parity_err=1, rx_dout=0x3C. Resend with bit 1 -> parity_err=0.
- **7-bit, framing:** 7E1 send 0x55, then 0x81 with stop forced 0 -> rx_dout=0x55, framing_err=0; then rx_dout=0x01, framing_err=1. Line held low enters rx_break with no further frames.
- **Glitch:** rx low for 4 baud ticks, then high -> no completion, state returns to rx_idle, all outputs unchanged.
- **Overflow:** RX_FIFO=0, receive 0x11 and 0x22 without a read -> rx_dout=0x11, overflow=1. clear_status -> overflow=0. Second case: completion coincident with read_rx_byte -> rx_dout=0x22, rxrdy=1, overflow=0.
- **FIFO mode:** RX_FIFO=1, receive 0x7E -> fifo_write_rx low exactly 1 clk with rx_dout=0x7E. Repeat with fifo_full=1 -> no strobe, overflow=1. Assert reset mid-data -> no strobe, all outputs at reset values.
